// File: rtl/magcompare_pkg.sv
// Shared types for the iterative magnitude comparator: FSM states and the
// registered three-way compare result.
package magcompare_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } cmp_state_t;

  typedef struct packed {
    logic lt;
    logic gt;
    logic eq;
  } cmp_result_t;

endpackage

// File: rtl/magcompare_iter_if.sv
// Operand/result handshake bundle for magcompare_iter; the comparator sits
// on the slave side.
interface magcompare_iter_if #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 2
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int NW   = $clog2(NDIG + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             is_signed;
  logic             out_valid;
  logic             out_ready;
  logic             LT;
  logic             GT;
  logic             EQ;
  logic [NW-1:0]    ndig_used;

  modport slave (
    input  in_valid, A, B, is_signed, out_ready,
    output in_ready, out_valid, LT, GT, EQ, ndig_used
  );

  modport master (
    output in_valid, A, B, is_signed, out_ready,
    input  in_ready, out_valid, LT, GT, EQ, ndig_used
  );
endinterface

// File: rtl/magcompare_digit.sv
// Combinational DIGIT-bit unsigned LT/GT cell; equality is implied when
// neither output is set.
module magcompare_digit #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  output logic             lt_o,
  output logic             gt_o
);

  assign lt_o = (a_i < b_i);
  assign gt_o = (a_i > b_i);

endmodule

// File: rtl/magcompare_iter.sv
// Sequential MSB-first magnitude comparator: one DIGIT-bit slice per cycle,
// stops at the first differing digit, result held until consumed.
module magcompare_iter
  import magcompare_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 2
) (
  input logic               clk,
  input logic               reset,
  magcompare_iter_if.slave  bus
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int NW   = $clog2(NDIG + 1);
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  cmp_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  cmp_result_t      res_q, res_d;
  logic [NW-1:0]    ndig_q, ndig_d;

  logic [DIGIT-1:0] a_dig, b_dig;
  logic             dig_lt, dig_gt;

  assign a_dig = DIGIT'(a_q >> (int'(idx_q) * DIGIT));
  assign b_dig = DIGIT'(b_q >> (int'(idx_q) * DIGIT));

  magcompare_digit #(.DIGIT(DIGIT)) u_digit (
    .a_i  (a_dig),
    .b_i  (b_dig),
    .lt_o (dig_lt),
    .gt_o (dig_gt)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    res_d   = res_q;
    ndig_d  = ndig_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d   = bus.A;
          b_d   = bus.B;
          // Flipping both sign bits maps two's-complement order onto unsigned order.
          if (bus.is_signed) begin
            a_d[WIDTH-1] = ~bus.A[WIDTH-1];
            b_d[WIDTH-1] = ~bus.B[WIDTH-1];
          end
          idx_d   = IW'(NDIG - 1);
          state_d = CMP;
        end
      end
      CMP: begin
        if (dig_lt || dig_gt) begin
          res_d   = '{lt: dig_lt, gt: dig_gt, eq: 1'b0};
          ndig_d  = NW'(NDIG - int'(idx_q));
          state_d = DONE;
        end else if (idx_q == '0) begin
          res_d   = '{lt: 1'b0, gt: 1'b0, eq: 1'b1};
          ndig_d  = NW'(NDIG);
          state_d = DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      DONE: begin
        // Clearing on exit keeps all flags low whenever out_valid is low.
        if (bus.out_ready) begin
          res_d   = '0;
          ndig_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      res_q   <= '0;
      ndig_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      ndig_q  <= ndig_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.LT        = res_q.lt;
  assign bus.GT        = res_q.gt;
  assign bus.EQ        = res_q.eq;
  assign bus.ndig_used = ndig_q;

endmodule

// File: tb/tb_magcompare_iter.sv
// Bench for magcompare_iter: directed WIDTH=8/DIGIT=2 scenarios plus a
// randomised WIDTH=16 sweep over several digit sizes, all scoreboard-checked.
module tb_magcompare_iter;

  typedef struct {
    bit lt;
    bit gt;
    bit eq;
    int nd;
  } exp_t;

  logic clk = 1'b0;
  logic rst8;
  logic rst16;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: order from integer value, ndig from the first differing digit.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input int w, input int d, input bit s);
    exp_t   e;
    longint va, vb, x, mask;
    int     n;
    n    = w / d;
    mask = (longint'(1) << d) - 1;
    va   = (s && a[w-1]) ? longint'(a) - (longint'(1) << w) : longint'(a);
    vb   = (s && b[w-1]) ? longint'(b) - (longint'(1) << w) : longint'(b);
    e.lt = (va < vb);
    e.gt = (va > vb);
    e.eq = (va == vb);
    e.nd = n;
    x    = longint'(a ^ b);
    for (int i = 0; i < n; i++) begin
      if (((x >> (w - d * (i + 1))) & mask) != 0) begin
        e.nd = i + 1;
        break;
      end
    end
    return e;
  endfunction

  // ---------------- directed instance: WIDTH=8, DIGIT=2 ----------------
  magcompare_iter_if #(.WIDTH(8), .DIGIT(2)) i8 ();
  magcompare_iter #(.WIDTH(8), .DIGIT(2)) u8 (.clk(clk), .reset(rst8), .bus(i8));

  exp_t q8[$];

  always @(negedge clk) begin : mon8
    exp_t e;
    if (!rst8) begin
      check("u8 onehot", i8.out_valid ? (int'(i8.LT) + int'(i8.GT) + int'(i8.EQ))
                                      : int'(i8.LT | i8.GT | i8.EQ),
            i8.out_valid ? 1 : 0);
      if (i8.out_valid && i8.out_ready) begin
        if (q8.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL u8 unexpected result: LT=%0d GT=%0d EQ=%0d", i8.LT, i8.GT, i8.EQ);
        end else begin
          e = q8.pop_front();
          check("u8 LT", i8.LT, e.lt);
          check("u8 GT", i8.GT, e.gt);
          check("u8 EQ", i8.EQ, e.eq);
          check("u8 ndig_used", i8.ndig_used, e.nd);
        end
      end
    end
  end

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input bit s, input bit push);
    bit ok;
    ok           = 0;
    i8.A         = a;
    i8.B         = b;
    i8.is_signed = s;
    i8.in_valid  = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (i8.in_ready) begin
        if (push) q8.push_back(model(32'(a), 32'(b), 8, 2, s));
        ok = 1;
        @(posedge clk);
        #1;
        break;
      end
    end
    i8.in_valid = 1'b0;
    if (!ok) begin
      checks++;
      fails++;
      $display("FAIL u8 accept timeout: got in_ready=0 expected 1");
    end
  endtask

  task automatic wait_out8(output int lat);
    lat = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      lat++;
      if (i8.out_valid) return;
    end
    checks++;
    fails++;
    $display("FAIL u8 result timeout: got out_valid=0 expected 1");
  endtask

  task automatic do_cmp8(input logic [7:0] a, input logic [7:0] b, input bit s);
    int lat;
    exp_t e;
    e = model(32'(a), 32'(b), 8, 2, s);
    send8(a, b, s, 1'b1);
    wait_out8(lat);
    check($sformatf("u8 latency %h/%h s=%0d", a, b, s), lat, e.nd + 1);
    @(posedge clk);
    #1;
  endtask

  // ---------------- random instances: WIDTH=16 ----------------
  initial begin
    rst16 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst16 = 1'b0;
  end

  for (genvar g = 0; g < 4; g++) begin : gr
    localparam int DG = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 16;
    magcompare_iter_if #(.WIDTH(16), .DIGIT(DG)) ib ();
    magcompare_iter #(.WIDTH(16), .DIGIT(DG)) ud (.clk(clk), .reset(rst16), .bus(ib));

    exp_t q[$];
    bit   done = 0;

    always @(posedge clk) begin
      #1 ib.out_ready = ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin : mon
      exp_t e;
      if (!rst16 && ib.out_valid && ib.out_ready) begin
        if (q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL D%0d unexpected result: LT=%0d GT=%0d EQ=%0d", DG, ib.LT, ib.GT, ib.EQ);
        end else begin
          e = q.pop_front();
          check($sformatf("D%0d LT", DG), ib.LT, e.lt);
          check($sformatf("D%0d GT", DG), ib.GT, e.gt);
          check($sformatf("D%0d EQ", DG), ib.EQ, e.eq);
          check($sformatf("D%0d ndig_used", DG), ib.ndig_used, e.nd);
        end
      end
    end

    initial begin : drv
      logic [15:0] a, b;
      bit s, ok;
      ib.in_valid  = 1'b0;
      ib.A         = '0;
      ib.B         = '0;
      ib.is_signed = 1'b0;
      ib.out_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      for (int n = 0; n < 60; n++) begin
        a = 16'($urandom_range(0, 65535));
        case ($urandom_range(0, 3))
          0:       b = a;
          1:       b = a ^ (16'd1 << $urandom_range(0, 15));
          default: b = 16'($urandom_range(0, 65535));
        endcase
        s            = 1'($urandom_range(0, 1));
        ib.A         = a;
        ib.B         = b;
        ib.is_signed = s;
        ib.in_valid  = 1'b1;
        ok           = 0;
        for (int t = 0; t < 200; t++) begin
          @(negedge clk);
          if (ib.in_ready) begin
            q.push_back(model(32'(a), 32'(b), 16, DG, s));
            ok = 1;
            @(posedge clk);
            #1;
            break;
          end
        end
        ib.in_valid = 1'b0;
        if (!ok) begin
          checks++;
          fails++;
          $display("FAIL D%0d accept timeout: got in_ready=0 expected 1", DG);
        end
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
      for (int t = 0; t < 500 && q.size() != 0; t++) @(posedge clk);
      check($sformatf("D%0d queue drained", DG), q.size(), 0);
      done = 1;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    bit alldone;
    int lat;
    rst8         = 1'b1;
    i8.in_valid  = 1'b0;
    i8.A         = '0;
    i8.B         = '0;
    i8.is_signed = 1'b0;
    i8.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset in_ready", i8.in_ready, 1);
    check("reset out_valid", i8.out_valid, 0);
    check("reset flags", {i8.LT, i8.GT, i8.EQ}, 0);
    check("reset ndig_used", i8.ndig_used, 0);
    @(posedge clk);
    #1 rst8 = 1'b0;

    do_cmp8(8'h80, 8'h7F, 1'b0);
    do_cmp8(8'h80, 8'h7F, 1'b1);
    do_cmp8(8'hFF, 8'h01, 1'b1);
    do_cmp8(8'h5A, 8'h5A, 1'b0);
    do_cmp8(8'h5A, 8'h5A, 1'b1);
    do_cmp8(8'h5B, 8'h5A, 1'b0);

    // Backpressure: result must hold while out_ready is low.
    i8.out_ready = 1'b0;
    send8(8'h5B, 8'h5A, 1'b0, 1'b1);
    wait_out8(lat);
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      check("bp out_valid", i8.out_valid, 1);
      check("bp GT", i8.GT, 1);
      check("bp in_ready", i8.in_ready, 0);
    end
    @(posedge clk);
    #1 i8.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp release in_ready", i8.in_ready, 1);
    check("bp release out_valid", i8.out_valid, 0);
    @(posedge clk);
    #1;
    do_cmp8(8'h12, 8'h34, 1'b0);

    // Reset during the second CMP cycle discards the compare.
    send8(8'h01, 8'h02, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst8 = 1'b1;
    @(posedge clk);
    #1 rst8 = 1'b0;
    @(negedge clk);
    check("midreset in_ready", i8.in_ready, 1);
    check("midreset out_valid", i8.out_valid, 0);
    repeat (6) @(posedge clk);
    #1;
    do_cmp8(8'h03, 8'h02, 1'b0);

    alldone = 0;
    for (int t = 0; t < 20000 && !alldone; t++) begin
      @(posedge clk);
      alldone = gr[0].done && gr[1].done && gr[2].done && gr[3].done;
    end
    check("random sweep finished", alldone, 1);
    check("u8 queue drained", q8.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
